alu_serial_bcd: RTL
===================

// Module: alu_serial_bcd
// PURPOSE
//  Parametrised-width ALU that processes operands one 4-bit digit per cycle, LSB digit first.
//  Provides binary add/sub, full decimal-adjusted BCD add/sub, logic ops and shift-right.
//  Intended for wide datapaths and multi-byte decimal arithmetic in 6502-family cores.
//  Start/done handshake plus an RDY stall input.
// PARAMETERS
//  WIDTH   16  operand width in bits; multiple of 4, range 8..32
//  DIGITS  WIDTH/4  localparam, not overridable: digit count and number of RUN cycles
// PORTS
//  clk      in   1      single clock, rising edge
//  reset_n  in   1      asynchronous active-low reset
//  RDY      in   1      global enable; when 0, all state and outputs hold
//  start    in   1      request; accepted on an edge where ready=1 and RDY=1
//  ready    out  1      1 in IDLE or DONE (combinational from state)
//  op       in   4      0011 A+B, 0111 A-B, 1011 A+A, 1100 A|B, 1101 A&B, 1110 A^B, 1111 A
//  right    in   1      1: shift right, overrides op
//  AI, BI   in   WIDTH  operands; latched on accept
//  CI       in   1      carry in; latched on accept
//  BCD      in   1      decimal mode for op 0011/0111 only; latched on accept
//  OUT      out  WIDTH  result
//  CO, V, Z, N, HC  out  1 each  flags
//  done     out  1      high for exactly one RDY-qualified cycle when results are valid
// BEHAVIOUR
//  Reset: state=IDLE; OUT, CO, V, Z, N, HC and done = 0. Takes effect at any time, including mid-RUN.
//  FSM:
//  - IDLE -> RUN on accept.
//  - RUN lasts DIGITS cycles, digit index 0..DIGITS-1, then -> DONE.
//  - DONE -> RUN on accept (back-to-back), else -> IDLE.
//  - start is ignored during RUN.
//  Latency: done=1 in the cycle after DIGITS RUN edges (WIDTH=16: 4 edges after the accept edge).
//  Result registers OUT and flags update only on the RUN->DONE edge and hold until the next one.
//  Per-digit op (k = index, carry chain c starts at latched CI):
//  - ADD: s = a_k + b_k + c.
//  - SUB: s = a_k + ~b_k + c (c=1 means no borrow).
//  - A+A: b_k replaced by a_k.
//  - Logic ops: carry forced to 0.
//  BCD add: if s>9 then digit=(s+6)[3:0], c=1; else c=s[4].
//  BCD sub: if s[4]=0 then digit=(s-6)[3:0], c=0; else c=1.
//  Operand digits >9 in BCD mode: result is defined purely by the rules above; no error is flagged.
//  Shift right: digit k = {bit 4k+4 (latched CI for the top bit), AI[4k+3:4k+1]}; CO=AI[0].
//  Flags:
//  - CO = final carry; 0 for logic ops.
//  - HC = carry out of digit 0.
//  - Z = (OUT==0); N = OUT[WIDTH-1].
//  - V = carry into MSB XOR binary (pre-adjust) carry out of MSB for add/sub/A+A; 0 for logic and shift.
//  RDY=0 freezes the FSM, digit index, partial result, carry and done (done stays high while frozen in DONE).
//  Operand inputs may change after accept without effect.
// STRUCTURE
//  Shared package alu_pkg:
//  - op encoding constants OP_ADD, OP_SUB, OP_ASL, OP_OR, OP_AND, OP_EOR, OP_PASS.
//  - state encoding IDLE/RUN/DONE.
//  Sub-module alu_digit: combinational 4-bit slice.
//  - Inputs: a, b, c_in, op, bcd.
//  - Outputs: digit, c_out, binary c_out, MSB carry-in.
//  Top level holds the FSM, a $clog2(DIGITS) counter, operand shift registers and the result accumulator.
// TESTING
//  1. WIDTH=16, BCD=1, ADD 0x0999+0x0001, CI=0 -> OUT=0x1000, CO=0, HC=1, Z=0, done 4 edges after accept.
//  2. BCD=1, SUB 0x1000-0x0001, CI=1 -> OUT=0x0999, CO=1, HC=0.
//  3. BCD=0, ADD 0x7FFF+0x0001, CI=0 -> OUT=0x8000, V=1, N=1, CO=0; then AND 0x00FF&0xFF00 -> OUT=0, Z=1, CO=0.
//  4. right=1, AI=0x0003, CI=1 -> OUT=0x8001, CO=1, V=0.
//  5. RDY low 3 cycles mid-RUN, then back-to-back start in DONE -> results unchanged vs no-stall; second done 4 RDY-cycles later.
//  6. reset_n low mid-RUN -> immediate IDLE, OUT=0, all flags 0, done=0; next start completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the digit-serial ALU: op encodings and FSM state codes.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_ASL  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1101;
    localparam logic [3:0] OP_EOR  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ASL);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational 4-bit ALU slice with optional decimal adjust for add/sub.
module alu_digit
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    input  logic [3:0] op,
    input  logic       bcd,
    output logic [3:0] digit,
    output logic       c_out,
    output logic       bin_c_out,
    output logic       msb_c_in
);

    logic [3:0] b_eff;
    logic [4:0] sum;
    logic [3:0] low;

    always_comb begin
        b_eff = b;
        if (op == OP_ASL)
            b_eff = a;
        else if (op == OP_SUB)
            b_eff = ~b;
        sum = {1'b0, a} + {1'b0, b_eff} + {4'b0000, c_in};
        // Carry into bit 3 feeds the signed-overflow flag at the top digit.
        low = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, c_in};

        digit     = sum[3:0];
        c_out     = sum[4];
        bin_c_out = sum[4];
        msb_c_in  = low[3];

        case (op)
            OP_ADD: begin
                if (bcd && (sum > 5'd9)) begin
                    digit = sum[3:0] + 4'd6;
                    c_out = 1'b1;
                end
            end
            OP_SUB: begin
                if (bcd && !sum[4]) begin
                    digit = sum[3:0] - 4'd6;
                    c_out = 1'b0;
                end
            end
            OP_ASL: ;
            OP_OR:   begin digit = a | b; c_out = 1'b0; end
            OP_AND:  begin digit = a & b; c_out = 1'b0; end
            OP_EOR:  begin digit = a ^ b; c_out = 1'b0; end
            default: begin digit = a;     c_out = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu_serial_bcd.sv
// Digit-serial ALU: one 4-bit digit per RDY-enabled cycle, LSB digit first,
// with start/done handshake and registered result/flags.
module alu_serial_bcd
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RDY,
    input  logic             start,
    output logic             ready,
    input  logic [3:0]       op,
    input  logic             right,
    input  logic [WIDTH-1:0] AI,
    input  logic [WIDTH-1:0] BI,
    input  logic             CI,
    input  logic             BCD,
    output logic [WIDTH-1:0] OUT,
    output logic             CO,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             HC,
    output logic             done
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d, hc_run_q, hc_run_d;
    logic             ci_q, ci_d, bcd_q, bcd_d, right_q, right_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d, hc_q, hc_d;

    logic [3:0]       slice_digit, dig;
    logic             slice_c, slice_bin_c, slice_msb_c, dig_c, last;
    logic [WIDTH-1:0] res_shift;

    alu_digit u_digit (
        .a         (a_q[3:0]),
        .b         (b_q[3:0]),
        .c_in      (carry_q),
        .op        (op_q),
        .bcd       (bcd_q),
        .digit     (slice_digit),
        .c_out     (slice_c),
        .bin_c_out (slice_bin_c),
        .msb_c_in  (slice_msb_c)
    );

    // Shift right takes bit 4k+4 from the next digit; the latched CI is shifted
    // in above the operand so the top digit picks it up naturally.
    always_comb begin
        last      = (cnt_q == CNT_W'(DIGITS - 1));
        dig       = right_q ? {a_q[4], a_q[3:1]} : slice_digit;
        dig_c     = right_q ? ((cnt_q == '0) ? a_q[0] : carry_q) : slice_c;
        res_shift = {dig, res_q[WIDTH-1:4]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        hc_run_d = hc_run_q;
        ci_d     = ci_q;
        bcd_d    = bcd_q;
        right_d  = right_q;
        op_d     = op_q;
        out_d    = out_q;
        co_d     = co_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        hc_d     = hc_q;

        if (RDY) begin
            case (state_q)
                RUN: begin
                    a_d     = {3'b000, ci_q, a_q[WIDTH-1:4]};
                    b_d     = {4'b0000, b_q[WIDTH-1:4]};
                    res_d   = res_shift;
                    carry_d = dig_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == '0)
                        hc_run_d = dig_c;
                    if (last) begin
                        state_d = DONE;
                        out_d   = res_shift;
                        co_d    = dig_c;
                        v_d     = (!right_q && is_arith(op_q)) ? (slice_msb_c ^ slice_bin_c) : 1'b0;
                        z_d     = (res_shift == '0);
                        n_d     = res_shift[WIDTH-1];
                        hc_d    = (cnt_q == '0) ? dig_c : hc_run_q;
                    end
                end
                default: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        a_d     = AI;
                        b_d     = BI;
                        carry_d = CI;
                        ci_d    = CI;
                        bcd_d   = BCD;
                        right_d = right;
                        op_d    = op;
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            hc_run_q <= 1'b0;
            ci_q     <= 1'b0;
            bcd_q    <= 1'b0;
            right_q  <= 1'b0;
            op_q     <= OP_PASS;
            out_q    <= '0;
            co_q     <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            hc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            hc_run_q <= hc_run_d;
            ci_q     <= ci_d;
            bcd_q    <= bcd_d;
            right_q  <= right_d;
            op_q     <= op_d;
            out_q    <= out_d;
            co_q     <= co_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
            hc_q     <= hc_d;
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign OUT   = out_q;
    assign CO    = co_q;
    assign V     = v_q;
    assign Z     = z_q;
    assign N     = n_q;
    assign HC    = hc_q;

endmodule
